countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter MAX_HOURS, default 23: largest accepted load value for Hours.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 TICK  input  1  one-cycle count-enable pulse, one per second, synchronous to CLK.
REQ-005 LOAD_VALID  input  1  load request; LOAD_H/M/S are valid while it is high.
REQ-006 LOAD_READY  output  1  high when a load can be accepted.
REQ-007 LOAD_H, LOAD_M, LOAD_S  input  6 each  preset hours, minutes, seconds.
REQ-008 START, PAUSE, CLEAR  input  1 each  single-cycle control pulses.
REQ-009 Hours, Mins, Secs  output  6 each  current remaining time, registered.
REQ-010 BUSY  output  1  high in RUN and PAUSED.
REQ-011 DONE  output  1  one-cycle pulse on expiry.
REQ-012 LOAD_ERR  output  1  one-cycle pulse on a rejected load.

Function
REQ-013 The FSM SHALL have four states: IDLE, LOADED, RUN, PAUSED.
REQ-014 LOAD_READY SHALL be high only in IDLE and LOADED, combinationally from state.
REQ-015 A load SHALL be accepted on a cycle with LOAD_VALID && LOAD_READY: next cycle Hours/Mins/Secs = LOAD_H/M/S and state = LOADED.
REQ-016 A load with LOAD_H > MAX_HOURS, LOAD_M > 59 or LOAD_S > 59 SHALL be rejected: counters and state unchanged, LOAD_ERR pulses for exactly the next cycle.
REQ-017 START in LOADED or PAUSED SHALL move to RUN; START in IDLE or RUN SHALL be ignored.
REQ-018 PAUSE in RUN SHALL move to PAUSED with counters frozen; PAUSE in other states SHALL be ignored.
REQ-019 CLEAR SHALL, from any state, zero Hours/Mins/Secs and move to IDLE next cycle without pulsing DONE.
REQ-020 Priority on the same cycle SHALL be CLEAR > load > PAUSE > START > TICK.
REQ-021 A TICK in RUN SHALL decrement once: Secs>0 -> Secs-1; else Mins>0 -> Mins-1, Secs=59; else Hours>0 -> Hours-1, Mins=59, Secs=59.
REQ-022 Outputs SHALL reflect a TICK on the cycle after it is sampled (latency 1).
REQ-023 When a TICK decrement yields 0:0:0, DONE SHALL pulse in the same cycle that shows 0:0:0, and state SHALL become IDLE.
REQ-024 START with a loaded value of 0:0:0 SHALL enter RUN, then pulse DONE and return to IDLE one cycle later, independent of TICK.
REQ-025 TICK outside RUN, and TICK on the same cycle as PAUSE or CLEAR, SHALL not change the counters.
REQ-026 Counters SHALL never underflow; Mins and Secs SHALL stay in 0..59 and Hours in 0..MAX_HOURS.
REQ-027 DONE and LOAD_ERR SHALL never be high for two consecutive cycles.

Reset
REQ-028 On RST_N low, immediately and independent of CLK: state=IDLE, Hours=Mins=Secs=0, DONE=0, LOAD_ERR=0, BUSY=0.
REQ-029 Reset asserted mid-RUN SHALL abort the countdown with no DONE pulse.
REQ-030 After RST_N deasserts, the first load SHALL be accepted on the first valid edge.

Verification
REQ-031 Load 0:1:2, START, 62 TICKs -> outputs 0:1:1, 0:1:0, 0:0:59 ... 0:0:0; DONE pulses exactly once on the 62nd, state IDLE.
REQ-032 Load 2:0:0, START, 1 TICK -> 1:59:59; 1 more TICK -> 1:59:58; BUSY=1 throughout.
REQ-033 Load 0:5:10, START, 3 TICKs, PAUSE, 10 TICKs, START, 1 TICK -> 0:5:07 held during pause, then 0:5:06.
REQ-034 Load 0:60:0 -> LOAD_ERR pulses one cycle, counters stay 0:0:0, state IDLE; load 24:0:0 with MAX_HOURS=23 -> same result.
REQ-035 Mid-RUN CLEAR asserted together with TICK -> next cycle 0:0:0, IDLE, DONE=0; mid-RUN RST_N low -> outputs 0 immediately, no DONE.
REQ-036 Load 0:0:0, START -> DONE pulses 2 cycles after START, LOAD_READY high again in IDLE.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: H:M:S countdown driven by a 1 Hz tick, with load/start/pause/clear control.
// Ports: clk, rst_n (async active-low); tick; load_valid/load_ready with load_h/m/s;
//        start/pause/clear pulses; hours/mins/secs remaining; busy, done, load_err status.
module countdown_timer #(
    parameter int MAX_HOURS = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [5:0] load_h,
    input  logic [5:0] load_m,
    input  logic [5:0] load_s,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [5:0] hours,
    output logic [5:0] mins,
    output logic [5:0] secs,
    output logic       busy,
    output logic       done,
    output logic       load_err
);
    typedef enum logic [1:0] {IDLE, LOADED, RUN, PAUSED} state_t;

    localparam logic [5:0] MAX_H = 6'(MAX_HOURS);

    state_t     state_q, state_d;
    logic [5:0] hours_q, hours_d, mins_q, mins_d, secs_q, secs_d;
    logic       done_q, done_d, load_err_q, load_err_d;
    logic       load_ok, zero;

    assign load_ready = state_q == IDLE || state_q == LOADED;
    assign busy       = state_q == RUN || state_q == PAUSED;
    assign hours      = hours_q;
    assign mins       = mins_q;
    assign secs       = secs_q;
    assign done       = done_q;
    assign load_err   = load_err_q;
    assign load_ok    = load_h <= MAX_H && load_m <= 6'd59 && load_s <= 6'd59;
    assign zero       = hours_q == 6'd0 && mins_q == 6'd0 && secs_q == 6'd0;

    always_comb begin
        state_d    = state_q;
        hours_d    = hours_q;
        mins_d     = mins_q;
        secs_d     = secs_q;
        done_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear) begin
            state_d = IDLE;
            hours_d = 6'd0;
            mins_d  = 6'd0;
            secs_d  = 6'd0;
        end else if (load_valid && load_ready) begin
            if (load_ok) begin
                state_d = LOADED;
                hours_d = load_h;
                mins_d  = load_m;
                secs_d  = load_s;
            end else begin
                // a held-high bad request must not produce back-to-back error pulses
                load_err_d = !load_err_q;
            end
        end else if (pause && state_q == RUN) begin
            state_d = PAUSED;
        end else if (start && (state_q == LOADED || state_q == PAUSED)) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (zero) begin
                // started at 0:0:0: expire immediately, no tick needed
                done_d  = 1'b1;
                state_d = IDLE;
            end else if (tick) begin
                if (secs_q != 6'd0) begin
                    secs_d = secs_q - 6'd1;
                end else if (mins_q != 6'd0) begin
                    mins_d = mins_q - 6'd1;
                    secs_d = 6'd59;
                end else begin
                    hours_d = hours_q - 6'd1;
                    mins_d  = 6'd59;
                    secs_d  = 6'd59;
                end
                if (hours_d == 6'd0 && mins_d == 6'd0 && secs_d == 6'd0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hours_q    <= 6'd0;
            mins_q     <= 6'd0;
            secs_q     <= 6'd0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hours_q    <= hours_d;
            mins_q     <= mins_d;
            secs_q     <= secs_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed and randomized checks of countdown_timer against a seconds-based model.
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, load_valid = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [5:0] load_h = 6'd0, load_m = 6'd0, load_s = 6'd0;
    logic       load_ready, busy, done, load_err;
    logic [5:0] hours, mins, secs;

    int n_chk = 0, n_pass = 0;
    // model: remaining time as total seconds, mode 0 idle, 1 loaded, 2 running, 3 paused
    int rem = 0, mode = 0;
    bit m_done = 0, m_err = 0;

    countdown_timer #(.MAX_HOURS(23)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .load_valid(load_valid), .load_ready(load_ready),
        .load_h(load_h), .load_m(load_m), .load_s(load_s), .start(start), .pause(pause),
        .clear(clear), .hours(hours), .mins(mins), .secs(secs), .busy(busy), .done(done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] tm();
        return {14'd0, hours, mins, secs};
    endfunction

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return {14'd0, 6'(h), 6'(m), 6'(s)};
    endfunction

    function automatic void model_step();
        bit prev_err = m_err;
        m_done = 0;
        m_err  = 0;
        if (clear) begin
            rem  = 0;
            mode = 0;
        end else if (load_valid && mode < 2) begin
            if (load_h <= 23 && load_m <= 59 && load_s <= 59) begin
                rem  = load_h * 3600 + load_m * 60 + load_s;
                mode = 1;
            end else m_err = !prev_err;
        end else if (pause && mode == 2) mode = 3;
        else if (start && (mode == 1 || mode == 3)) mode = 2;
        else if (mode == 2) begin
            if (rem == 0) begin
                m_done = 1;
                mode   = 0;
            end else if (tick) begin
                rem--;
                if (rem == 0) begin
                    m_done = 1;
                    mode   = 0;
                end
            end
        end
    endfunction

    task automatic cmp(input string tag);
        chk({tag, "_time"}, tm(), hms(rem / 3600, (rem / 60) % 60, rem % 60));
        chk({tag, "_flags"}, {28'd0, busy, done, load_err, load_ready},
            {28'd0, mode >= 2, m_done, m_err, mode < 2});
    endtask

    task automatic step(input bit tk, input bit lv, input int lh, input int lm, input int ls,
                        input bit st, input bit pa, input bit cl, input string tag);
        tick = tk; load_valid = lv; load_h = 6'(lh); load_m = 6'(lm); load_s = 6'(ls);
        start = st; pause = pa; clear = cl;
        @(posedge clk);
        model_step();
        @(negedge clk);
        cmp(tag);
        tick = 0; load_valid = 0; start = 0; pause = 0; clear = 0;
    endtask

    task automatic load(input int h, input int m, input int s, input string tag);
        step(0, 1, h, m, s, 0, 0, 0, tag);
    endtask

    initial begin
        int nd;
        #1;
        chk("reset_time", tm(), 32'd0);
        chk("reset_flags", {28'd0, busy, done, load_err, load_ready}, 32'h1);
        #11 rst_n = 1'b1;

        load(0, 1, 2, "r031_load");
        chk("r031_loaded", tm(), hms(0, 1, 2));
        step(0, 0, 0, 0, 0, 1, 0, 0, "r031_start");
        nd = 0;
        for (int i = 0; i < 62; i++) begin
            step(1, 0, 0, 0, 0, 0, 0, 0, "r031_tick");
            nd += int'(done);
        end
        chk("r031_done_cnt", 32'(nd), 32'd1);
        chk("r031_end", tm(), 32'd0);

        load(2, 0, 0, "r032_load");
        step(0, 0, 0, 0, 0, 1, 0, 0, "r032_start");
        step(1, 0, 0, 0, 0, 0, 0, 0, "r032_t1");
        chk("r032_a", tm(), hms(1, 59, 59));
        step(1, 0, 0, 0, 0, 0, 0, 0, "r032_t2");
        chk("r032_b", tm(), hms(1, 59, 58));
        chk("r032_busy", 32'(busy), 32'd1);

        step(0, 0, 0, 0, 0, 0, 0, 1, "clr");
        load(0, 5, 10, "r033_load");
        step(0, 0, 0, 0, 0, 1, 0, 0, "r033_start");
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, "r033_run");
        step(1, 0, 0, 0, 0, 0, 1, 0, "r033_pause");
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0, 0, "r033_held");
        chk("r033_held", tm(), hms(0, 5, 7));
        step(0, 0, 0, 0, 0, 1, 0, 0, "r033_resume");
        step(1, 0, 0, 0, 0, 0, 0, 0, "r033_tick");
        chk("r033_end", tm(), hms(0, 5, 6));

        step(0, 0, 0, 0, 0, 0, 0, 1, "clr");
        load(0, 60, 0, "r034_m60");
        chk("r034_err_m", {30'd0, load_err, load_ready}, 32'h3);
        step(0, 0, 0, 0, 0, 0, 0, 0, "r034_gap");
        load(24, 0, 0, "r034_h24");
        chk("r034_err_h", {30'd0, load_err, load_ready}, 32'h3);
        load(0, 0, 60, "r034_s60");
        step(0, 0, 0, 0, 0, 0, 0, 0, "r034_after");

        load(0, 0, 30, "r035_load");
        step(0, 0, 0, 0, 0, 1, 0, 0, "r035_start");
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 0, "r035_run");
        step(1, 0, 0, 0, 0, 0, 0, 1, "r035_clear");
        chk("r035_clr", {14'd0, hours, mins, secs} | {31'd0, done}, 32'd0);
        load(0, 0, 30, "r035_load2");
        step(0, 0, 0, 0, 0, 1, 0, 0, "r035_start2");
        step(1, 0, 0, 0, 0, 0, 0, 0, "r035_run2");
        #2 rst_n = 1'b0;
        #1;
        chk("r035_rst", {14'd0, hours, mins, secs} | {30'd0, busy, done}, 32'd0);
        rem = 0; mode = 0; m_done = 0; m_err = 0;
        @(negedge clk);
        cmp("r035_in_rst");
        #2 rst_n = 1'b1;
        @(negedge clk);
        load(0, 0, 0, "r036_load");
        step(0, 0, 0, 0, 0, 1, 0, 0, "r036_start");
        step(0, 0, 0, 0, 0, 0, 0, 0, "r036_expire");
        chk("r036_done", {30'd0, done, load_ready}, 32'h3);
        step(0, 0, 0, 0, 0, 0, 0, 0, "r036_after");

        for (int i = 0; i < 4000; i++) begin
            int lh, lm, ls;
            lh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : 0;
            lm = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 61)) : int'($urandom_range(0, 1));
            ls = int'($urandom_range(0, 61));
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 8, lh, lm, ls,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5,
                 $urandom_range(0, 99) < 1, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
